// File: rtl/clock_divider_bank.sv
// ---------------------------------------------------------------------------
// clock_divider_bank
//   A bank of N_CH independent, programmable clock dividers that share one
//   input clock. Each channel counts enabled cycles up to its active divisor
//   and then toggles a registered 50%-duty output. The half-period is
//   div_act+1 cycles and the full period is 2*(div_act+1) cycles.
//
//   A new divisor written over the config port is first held as "pending".
//   It becomes active only at a safe point: the terminal-count edge, any
//   edge where the channel is stalled, or a bank-wide sync. As a result the
//   output never produces a truncated half-period.
//
// Ports
//   clk_in   in   1      single clock, rising edge
//   rst      in   1      synchronous, active-high reset
//   en       in   N_CH   per-channel count enable
//   sync     in   1      restart every channel at cnt=0 / clk_out=0
//   cfg_we   in   1      divisor write strobe
//   cfg_ch   in   CH_W   channel targeted by the write
//   cfg_div  in   WIDTH  divisor value to write
//   clk_out  out  N_CH   divided clocks (registered)
//   tick     out  N_CH   high in the cycle after each clk_out toggle
//   cfg_err  out  1      one-cycle pulse after a write to a channel >= N_CH
// ---------------------------------------------------------------------------
module clock_divider_bank #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 20,
  parameter int DIV_INIT = 249999,
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic             cfg_err
);

  // The index port can encode values past the last channel when N_CH is not
  // a power of two. Writes to those values are rejected and flagged.
  logic cfg_in_range;
  assign cfg_in_range = (32'(cfg_ch) < 32'(N_CH));

  // NOTE: every sequential block uses non-blocking assignments. All flops
  // then sample pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk_in) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && !cfg_in_range;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic             pend_valid;
    logic             clk_q;
    logic             tick_q;

    logic wr_hit;
    logic at_term;
    logic apply;

    assign wr_hit  = cfg_we && cfg_in_range && (cfg_ch == CH_W'(i));
    assign at_term = (cnt == div_act);
    // A pending divisor is swapped in only where the current half-period has
    // just finished (terminal count), where no counting happens (stalled),
    // or where the counter restarts anyway (sync).
    assign apply   = pend_valid && (sync || !en[i] || at_term);

    always_ff @(posedge clk_in) begin
      if (rst) begin
        cnt        <= '0;
        div_act    <= WIDTH'(DIV_INIT);
        div_pend   <= '0;
        pend_valid <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        if (sync) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (en[i]) begin
          if (at_term) begin
            cnt    <= '0;
            clk_q  <= ~clk_q;
            tick_q <= 1'b1;
          end else begin
            cnt    <= cnt + 1'b1;
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
          // A stalled channel may sit above the divisor it is about to
          // adopt. Without this restart it would count up through 2^WIDTH
          // before reaching terminal count again.
          if (apply && (cnt > div_pend)) cnt <= '0;
        end

        if (apply) begin
          div_act    <= div_pend;
          pend_valid <= 1'b0;
        end
        // This assignment comes after the apply block on purpose. A write
        // that lands on an apply edge stays pending, and the older pending
        // value is the one that goes live.
        if (wr_hit) begin
          div_pend   <= cfg_div;
          pend_valid <= 1'b1;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// ---------------------------------------------------------------------------
// tb_clock_divider_bank
//   Self-checking bench for clock_divider_bank with N_CH=3, WIDTH=4 and
//   DIV_INIT=3. Channel 2 stays disabled. Each vector drives one clock
//   edge, and every expected output is a hand-derived constant. Expected
//   outputs are queued when a vector is driven and popped once the edge
//   has produced the DUT response.
// ---------------------------------------------------------------------------
module tb_clock_divider_bank;

  localparam int N_CH     = 3;
  localparam int WIDTH    = 4;
  localparam int DIV_INIT = 3;
  localparam int CH_W     = 2;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic             cfg_err;

  clock_divider_bank #(
    .N_CH     (N_CH),
    .WIDTH    (WIDTH),
    .DIV_INIT (DIV_INIT),
    .CH_W     (CH_W)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .clk_out (clk_out),
    .tick    (tick),
    .cfg_err (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic       sync;
    logic       we;
    logic [1:0] ch;
    logic [3:0] div;
    logic [2:0] exp_clk;
    logic [2:0] exp_tick;
    logic       exp_err;
  } vec_t;

  typedef struct {
    int         idx;
    logic [2:0] clk;
    logic [2:0] tick;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_vec = 0;

  function automatic vec_t mk(input logic r, input logic [2:0] e, input logic s,
                              input logic w, input logic [1:0] c, input logic [3:0] d,
                              input logic [2:0] xc, input logic [2:0] xt, input logic xe);
    vec_t v;
    v.rst = r; v.en = e; v.sync = s; v.we = w; v.ch = c; v.div = d;
    v.exp_clk = xc; v.exp_tick = xt; v.exp_err = xe;
    return v;
  endfunction

  // Plain counting edge: no reset, no sync, no config write.
  function automatic vec_t run(input logic [2:0] e, input logic [2:0] xc, input logic [2:0] xt);
    return mk(1'b0, e, 1'b0, 1'b0, 2'd0, 4'd0, xc, xt, 1'b0);
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t x;
    rst     = v.rst;
    en      = v.en;
    sync    = v.sync;
    cfg_we  = v.we;
    cfg_ch  = v.ch;
    cfg_div = v.div;
    x.idx  = n_vec;
    x.clk  = v.exp_clk;
    x.tick = v.exp_tick;
    x.err  = v.exp_err;
    sb.push_back(x);
    n_vec++;
    @(posedge clk_in);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      x = sb.pop_front();
      check($sformatf("v%0d clk_out", x.idx), clk_out, x.clk);
      check($sformatf("v%0d tick", x.idx), tick, x.tick);
      check($sformatf("v%0d cfg_err", x.idx), {2'b00, cfg_err}, {2'b00, x.err});
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;

    // ---- main table: reset, divide-by-8, divisor change, stall, div=0,
    // ---- out-of-range write, sync with a same-edge write, sync realign
    vecs.push_back(mk(1, 3'b011, 0, 0, 2'd0, 4'd0, 3'b000, 3'b000, 0)); // reset
    vecs.push_back(run(3'b011, 3'b000, 3'b000));                        // cnt 1
    vecs.push_back(run(3'b011, 3'b000, 3'b000));                        // cnt 2
    vecs.push_back(run(3'b011, 3'b000, 3'b000));                        // cnt 3
    vecs.push_back(run(3'b011, 3'b011, 3'b011));                        // toggle, in phase
    vecs.push_back(run(3'b011, 3'b011, 3'b000));
    vecs.push_back(run(3'b011, 3'b011, 3'b000));
    vecs.push_back(run(3'b011, 3'b011, 3'b000));
    vecs.push_back(run(3'b011, 3'b000, 3'b011));                        // period 8
    vecs.push_back(run(3'b011, 3'b000, 3'b000));                        // cnt1 = 1
    vecs.push_back(mk(0, 3'b011, 0, 1, 2'd1, 4'd1, 3'b000, 3'b000, 0)); // write ch1 div=1
    vecs.push_back(run(3'b011, 3'b000, 3'b000));
    vecs.push_back(run(3'b011, 3'b011, 3'b011));                        // ch1 finishes 4-cycle half
    vecs.push_back(run(3'b011, 3'b011, 3'b000));
    vecs.push_back(run(3'b011, 3'b001, 3'b010));                        // ch1 now every 2
    vecs.push_back(run(3'b011, 3'b001, 3'b000));
    vecs.push_back(run(3'b011, 3'b010, 3'b011));
    vecs.push_back(run(3'b011, 3'b010, 3'b000));
    vecs.push_back(run(3'b011, 3'b000, 3'b010));                        // cnt0 = 2
    vecs.push_back(run(3'b010, 3'b000, 3'b000));                        // ch0 stalled x5
    vecs.push_back(run(3'b010, 3'b010, 3'b010));
    vecs.push_back(run(3'b010, 3'b010, 3'b000));
    vecs.push_back(run(3'b010, 3'b000, 3'b010));
    vecs.push_back(run(3'b010, 3'b000, 3'b000));
    vecs.push_back(run(3'b011, 3'b010, 3'b010));                        // re-enable
    vecs.push_back(run(3'b011, 3'b011, 3'b001));                        // ch0 toggles 2 later
    vecs.push_back(mk(0, 3'b011, 0, 1, 2'd0, 4'd0, 3'b001, 3'b010, 0)); // write ch0 div=0
    vecs.push_back(run(3'b011, 3'b001, 3'b000));
    vecs.push_back(run(3'b011, 3'b011, 3'b010));
    vecs.push_back(run(3'b011, 3'b010, 3'b001));                        // ch0 terminal, div 0 live
    vecs.push_back(run(3'b011, 3'b001, 3'b011));
    vecs.push_back(run(3'b011, 3'b000, 3'b001));
    vecs.push_back(run(3'b011, 3'b011, 3'b011));
    vecs.push_back(run(3'b011, 3'b010, 3'b001));
    vecs.push_back(mk(0, 3'b011, 0, 1, 2'd3, 4'd5, 3'b001, 3'b011, 1)); // bad channel
    vecs.push_back(run(3'b011, 3'b000, 3'b001));                        // err gone, no div change
    vecs.push_back(run(3'b011, 3'b011, 3'b011));
    vecs.push_back(run(3'b011, 3'b010, 3'b001));
    vecs.push_back(mk(0, 3'b011, 1, 1, 2'd0, 4'd1, 3'b000, 3'b000, 0)); // sync + write ch0 div=1
    vecs.push_back(run(3'b011, 3'b001, 3'b001));                        // old div 0 still live
    vecs.push_back(run(3'b011, 3'b011, 3'b010));
    vecs.push_back(run(3'b011, 3'b010, 3'b001));                        // div 1 now live
    vecs.push_back(mk(0, 3'b011, 1, 0, 2'd0, 4'd0, 3'b000, 3'b000, 0)); // sync mid-count
    vecs.push_back(run(3'b011, 3'b000, 3'b000));
    vecs.push_back(run(3'b011, 3'b011, 3'b011));                        // in phase
    vecs.push_back(run(3'b011, 3'b011, 3'b000));
    vecs.push_back(run(3'b011, 3'b000, 3'b011));

    foreach (vecs[k]) drive(vecs[k]);

    // ---- stalled apply with cnt above the new divisor must restart cnt
    drive(mk(0, 3'b011, 0, 1, 2'd0, 4'd3, 3'b000, 3'b000, 0));   // write ch0 div=3
    drive(run(3'b011, 3'b011, 3'b011));                          // applied at terminal
    drive(run(3'b011, 3'b011, 3'b000));
    drive(run(3'b011, 3'b001, 3'b010));
    drive(run(3'b011, 3'b001, 3'b000));                          // cnt0 = 3
    drive(mk(0, 3'b010, 0, 1, 2'd0, 4'd1, 3'b011, 3'b010, 0));   // stalled, write div=1
    drive(run(3'b010, 3'b011, 3'b000));                          // applied, cnt0 -> 0
    drive(run(3'b011, 3'b001, 3'b010));
    drive(run(3'b011, 3'b000, 3'b001));                          // toggle after 2 cycles

    // ---- reset with a pending write and clk_out high
    drive(mk(0, 3'b011, 0, 1, 2'd1, 4'd0, 3'b010, 3'b010, 0));   // ch1 pending div=0
    drive(mk(1, 3'b011, 1, 1, 2'd3, 4'd0, 3'b000, 3'b000, 0));   // rst beats sync/cfg
    drive(run(3'b011, 3'b000, 3'b000));
    drive(run(3'b011, 3'b000, 3'b000));
    drive(run(3'b011, 3'b000, 3'b000));
    drive(run(3'b011, 3'b011, 3'b011));                          // div_act back to 3
    drive(run(3'b011, 3'b011, 3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 20: width of the divisor and counter.
REQ-003 The block SHALL have parameter DIV_INIT, default 249999: active divisor of every channel after reset.
REQ-004 The block SHALL have parameter CH_W, default max(1, clog2(N_CH)): width of the channel index.
REQ-005 The block SHALL have port clk_in, input, 1: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port en, input, N_CH: per-channel count enable.
REQ-008 The block SHALL have port sync, input, 1: restart all channels in phase.
REQ-009 The block SHALL have port cfg_we, input, 1: divisor write strobe.
REQ-010 The block SHALL have port cfg_ch, input, CH_W: target channel of the write.
REQ-011 The block SHALL have port cfg_div, input, WIDTH: divisor value to write.
REQ-012 The block SHALL have port clk_out, output, N_CH: per-channel divided clock (registered, 50% duty).
REQ-013 The block SHALL have port tick, output, N_CH: one-cycle pulse, high in the cycle after each clk_out toggle.
REQ-014 The block SHALL have port cfg_err, output, 1: one-cycle pulse flagging an out-of-range cfg_ch.

Function
REQ-015 Each channel SHALL hold cnt (WIDTH), div_act (WIDTH), div_pend (WIDTH) and pend_valid.
REQ-016 Priority per edge SHALL be: rst, then sync, then count/enable logic; cfg capture is independent of sync and count.
REQ-017 With en[i]=1 and cnt!=div_act, cnt SHALL increment by 1 and tick[i] SHALL be 0.
REQ-018 With en[i]=1 and cnt==div_act: cnt<=0, clk_out[i] toggles, tick[i]<=1; half-period = div_act+1 cycles, full period = 2*(div_act+1).
REQ-019 div_act=0 SHALL toggle clk_out every cycle with tick held at 1.
REQ-020 With en[i]=0: cnt and clk_out[i] SHALL hold, and tick[i] SHALL be 0.
REQ-021 cfg_we=1 with cfg_ch<N_CH SHALL set div_pend<=cfg_div and pend_valid<=1 for that channel; a later write before apply SHALL overwrite it.
REQ-022 A pending divisor SHALL be applied (div_act<=div_pend, pend_valid<=0) on the edge where the channel reaches terminal count, or on any edge with en[i]=0, or on sync.
REQ-023 A write on the same edge as an apply event for the same channel SHALL remain pending; the previously pending value, if any, is applied.
REQ-024 Since div_act changes only when cnt returns to 0 or the channel is stalled at any cnt, a stalled-channel apply with cnt>new div_act SHALL also clear cnt<=0 (no counter wrap through 2^WIDTH).
REQ-025 sync=1 SHALL force cnt<=0, clk_out<=0 and tick<=0 on all channels regardless of en.
REQ-026 cfg_we=1 with cfg_ch>=N_CH SHALL change no state and SHALL pulse cfg_err=1 for exactly the next cycle.

Reset
REQ-027 On rst=1 at an edge, every channel SHALL set cnt=0, clk_out=0, tick=0, div_act=DIV_INIT, pend_valid=0; cfg_err SHALL be 0. Pending writes are discarded.
REQ-028 rst SHALL override sync and cfg_we in the same cycle.

Verification
REQ-029 N_CH=2, WIDTH=4, DIV_INIT=3, release rst with en=2'b11 -> both clk_out toggle every 4 cycles (period 8), tick pulses every 4th cycle, channels in phase.
REQ-030 Same config, write ch1 div=1 when cnt1=1 -> ch1 completes current 4-cycle half-period, then toggles every 2 cycles; ch0 unchanged.
REQ-031 Write ch0 div=0 -> after next terminal count clk_out[0] toggles every cycle, tick[0] constant 1.
REQ-032 Drop en[0] for 5 cycles at cnt0=2 -> clk_out[0] held, tick[0]=0; re-enable -> toggle exactly 2 cycles later.
REQ-033 N_CH=3 (CH_W=2), cfg_we with cfg_ch=3 -> cfg_err high one cycle, no divisor changes; then sync mid-count -> all clk_out=0, all cnt=0, in phase after.
REQ-034 Assert rst with a pending write on ch1 and clk_out=1 -> all outputs 0 next cycle, div_act=3, pending value never applied.
